// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - request/result bundle for the chunked adder/subtractor
interface seq_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_sub, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_sub, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_cout, o_ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle adder/subtractor, CHUNK bits per clock with a registered carry
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_msb_cin;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);

  // The carry into a chunk's top bit is recovered from that bit's operands and sum,
  // which on the last chunk is exactly the carry into the word MSB.
  always_comb begin
    w_a_slice = r_op_a[int'(r_idx) * CHUNK +: CHUNK];
    w_b_slice = r_op_b[int'(r_idx) * CHUNK +: CHUNK];
    {w_chunk_cout, w_chunk_sum} = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_idx) * CHUNK +: CHUNK] = w_chunk_sum;
    w_msb_cin = w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: B is inverted and cin becomes ~borrow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_op_a  <= bus.i_a;
            r_op_b  <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_cin ^ bus.i_sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_chunk_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_sum  <= w_acc_nxt;
            r_cout <= w_chunk_cout;
            r_ovf  <= w_msb_cin ^ w_chunk_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_busy = (r_state == S_RUN);
  assign bus.o_done = (r_state == S_DONE);
  assign bus.o_sum  = r_sum;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;
endmodule
